// File: rtl/booth_multiplier_controller.sv
// Sequential radix-2 Booth signed multiplier. One shared adder/subtracter is used
// for every add/subtract step; each step takes one OP cycle and one SHIFT cycle.
module binary_adder_subtracter_module #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             s,
  output logic [width-1:0] sum,
  output logic             v
);
  logic [width-1:0] b_eff;
  logic [width-1:0] cin;

  assign b_eff = b ^ {width{s}};
  assign cin   = {{(width-1){1'b0}}, s};
  assign sum   = a + b_eff + cin;
  // Signed overflow: operands agree in sign but the result does not.
  assign v     = (a[width-1] == b_eff[width-1]) && (sum[width-1] != a[width-1]);
endmodule

module booth_multiplier_controller #(
  parameter int width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width-1:0]     multiplicand,
  input  logic [width-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   product
);
  localparam int CW = $clog2(width) + 1;

  typedef enum logic [1:0] {IDLE, OP, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [width-1:0] a_q;
  logic [width-1:0] q_q;
  logic [width-1:0] m_q;
  logic             q1_q;
  logic             sgn_q;
  logic [CW-1:0]    count_q;

  logic             sub;
  logic [width-1:0] sum;
  logic             v;

  assign sub = q_q[0] & ~q1_q;

  binary_adder_subtracter_module #(.width(width)) u_addsub (
    .a   (a_q),
    .b   (m_q),
    .s   (sub),
    .sum (sum),
    .v   (v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      sgn_q   <= 1'b0;
      count_q <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= CW'(width);
            busy    <= 1'b1;
            state_q <= OP;
          end
        end
        OP: begin
          if (q_q[0] ^ q1_q) begin
            a_q   <= sum;
            sgn_q <= sum[width-1] ^ v;
          end else begin
            sgn_q <= a_q[width-1];
          end
          state_q <= SHIFT;
        end
        SHIFT: begin
          a_q     <= {sgn_q, a_q[width-1:1]};
          q_q     <= {a_q[0], q_q[width-1:1]};
          q1_q    <= q_q[0];
          count_q <= count_q - CW'(1);
          // Product is captured from the shifted value so it is valid alongside done.
          if (count_q == CW'(1)) begin
            product <= {sgn_q, a_q, q_q[width-1:1]};
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= OP;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_multiplier_controller.sv
// Directed bench for booth_multiplier_controller (width=4) with hand-computed products.
module tb_booth_multiplier_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] multiplicand = '0;
  logic [3:0] multiplier = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  booth_multiplier_controller #(.width(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until done is seen; n = negedges taken (30 = timeout).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
  endtask

  task automatic run_op(input string tag, input logic [3:0] m, input logic [3:0] q,
                        input logic [7:0] exp, input logic [7:0] prev);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    check({tag, "_prev_held"}, product, prev);
    for (int n = 1; n <= 20 && done_at == 0; n++) begin
      if (busy) busy_cnt++;
      if (done) done_at = n;
      else @(negedge clk);
    end
    check({tag, "_latency"}, done_at, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    check({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    int n;
    int n2;
    int seen;

    #12;
    check("reset_state", {busy, done, product}, 10'h000);
    @(negedge clk);
    rst = 1'b0;

    run_op("3x5",   4'h3, 4'h5, 8'h0F, 8'h00);
    run_op("m3x5",  4'hD, 4'h5, 8'hF1, 8'h0F);
    run_op("5xm3",  4'h5, 4'hD, 8'hF1, 8'hF1);
    run_op("m8xm8", 4'h8, 4'h8, 8'h40, 8'hF1);
    run_op("7xm8",  4'h7, 4'h8, 8'hC8, 8'h40);
    run_op("m8x7",  4'h8, 4'h7, 8'hC8, 8'hC8);
    run_op("0xm1",  4'h0, 4'hF, 8'h00, 8'hC8);
    run_op("m1xm1", 4'hF, 4'hF, 8'h01, 8'h00);

    // Start re-pulsed with new operands while busy must be ignored.
    @(negedge clk);
    multiplicand = 4'h3;
    multiplier   = 4'h5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    multiplicand = 4'h2;
    multiplier   = 4'h5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("midop_latency", n, 5);
    check("midop_product", product, 8'h0F);
    repeat (3) @(negedge clk);
    check("midop_no_restart", {busy, done}, 2'b00);

    // Start held high: back-to-back operations.
    multiplicand = 4'h7;
    multiplier   = 4'h7;
    start        = 1'b1;
    wait_done(n);
    check("held_first_latency", n, 9);
    check("held_first_product", product, 8'h31);
    wait_done(n2);
    start = 1'b0;
    check("held_period", n2, 10);
    check("held_second_product", product, 8'h31);
    repeat (3) @(negedge clk);
    check("held_released_idle", busy, 1'b0);

    // Asynchronous reset between edges mid-operation.
    multiplicand = 4'h3;
    multiplier   = 4'h5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {busy, done, product}, 10'h000);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no_done_after_abort", seen, 0);

    run_op("post_reset_3x5", 4'h3, 4'h5, 8'h0F, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/booth_multiplier_controller.md
Name: booth_multiplier_controller

Overview:
Sequential signed (two's-complement) multiplier built around one shared binary_adder_subtracter_module instance (ports a, b, s, sum, v). An FSM applies radix-2 Booth recoding: each multiplier bit pair selects add, subtract or no-op on the accumulator, followed by an arithmetic right shift. The adder's v output corrects the shifted-in sign bit when the accumulator overflows. The block sits between the operand source and result consumer as the datapath's first multi-cycle user of the adder/subtracter.

Parameters:
width, 4, operand width in bits (product is 2*width); must be >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
multiplicand  input  width  signed operand M, captured at accepted start
multiplier  input  width  signed operand Q, captured at accepted start
busy  output  1  high from cycle after accepted start through DONE cycle
done  output  1  one-cycle pulse, product valid
product  output  2*width  signed result {A,Q}; held until next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE; A, Q, Q_1, M, count, product cleared to 0; busy=0, done=0. Reset mid-operation aborts; no done pulse.
- Registers: A (width, accumulator), Q (width), Q_1 (1), M (width), count (log2(width)+1 bits).
- IDLE: busy=0. Edge with start=1 loads M=multiplicand, Q=multiplier, A=0, Q_1=0, count=width; next state OP.
- OP (1 cycle): adder a=A, b=M. {Q[0],Q_1}=10 -> s=1, A<=sum, sgn<=sum[width-1]^v. 01 -> s=0, A<=sum, sgn<=sum[width-1]^v. 00/11 -> A unchanged, sgn<=A[width-1]. Next state SHIFT.
- SHIFT (1 cycle): {A,Q,Q_1} <= {sgn, A, Q} (arithmetic right shift; MSB is the true sign sgn, not raw A MSB); count<=count-1. If count==1, next DONE, else OP.
- DONE (1 cycle): product<={A,Q}; done=1; busy=1; next IDLE.
- Latency: start accepted at edge k -> done high during cycle k+2*width+1 (9 cycles after acceptance for width=4). Fixed, independent of operand values; no-op iterations still take 2 cycles.
- start while busy (OP/SHIFT/DONE) ignored; operand inputs ignored outside the accepting edge.
- start held high continuously: new operation accepted on the edge after DONE (back-to-back period 2*width+2 cycles).
- Overflow: v=1 only when A±M exceeds width bits (e.g. M=most negative). The sgn correction makes the result exact for all operand pairs, including -2^(width-1) * -2^(width-1). No overflow output; product width is always sufficient.
- done, busy registered/state-decoded; no combinational path from start to outputs.

Test Plan:
- 3 * 5 (M=0011, Q=0101), start pulse -> done after 9 cycles, product=8'h0F, busy high 9 cycles.
- -3 * 5 (M=1101, Q=0101) -> product=8'hF1 (-15); M=0101, Q=1101 -> 8'hF1.
- -8 * -8 (M=1000, Q=1000) -> product=8'h40 (+64), exercises v-based sign correction; 7 * -8 -> 8'hC8; -8 * 7 -> 8'hC8.
- 0 * -1 (M=0000, Q=1111) -> 8'h00; -1 * -1 -> 8'h01; product from prior op stays stable until done.
- start re-pulsed with new operands (2*5) mid-operation of 3*5 -> ignored, product=8'h0F; start held high -> second op accepted edge after DONE, done pulses 10 cycles apart.
- rst asserted asynchronously mid-OP (between edges) -> busy, done, product go 0 immediately; no done pulse; next start completes normally with correct result.
